// File: rtl/poll_pkg.sv
// Shared types and helpers for the burst read scheduler.
package poll_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Cycles spent after the last read so the final word lands and levels settle
  localparam int DRAIN_CYC = 2;

  // Widest channel count the picker handles
  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of eligible at or after ptr, wrapping within n channels.
  // Scans from the far end down so the smallest offset is the final write.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] eligible,
                                       input logic [3:0]        ptr,
                                       input int                n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int i = RR_MAX-1; i >= 0; i--) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j -= n;
        if (eligible[j]) begin
          r.found = 1'b1;
          r.idx   = 4'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the caller registers the result.
module rr_arbiter
  import poll_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          valid
);

  rr_pick_t pick;

  // Search starts at ptr so the last-served channel goes to the back
  always_comb begin
    pick  = rr_pick(RR_MAX'(eligible), 4'(ptr), N);
    gnt   = IW'(pick.idx);
    valid = pick.found;
  end

endmodule

// File: rtl/poll_burst_arbiter.sv
// Burst read scheduler: grants one FIFO channel at a time in round-robin
// order and drains a fixed-length burst onto a single tagged stream.
module poll_burst_arbiter
  import poll_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DW     = 64,
  parameter int LW     = 13,
  parameter int BURST  = 128,
  parameter int CW     = $clog2(CH_NUM)
) (
  input  logic                 rdclk,
  input  logic                 rst_n,
  input  logic [CH_NUM*LW-1:0] ch_level,
  input  logic [CH_NUM*DW-1:0] ch_q,
  output logic [CH_NUM-1:0]    ch_rdreq,
  input  logic                 up_ready,
  output logic                 up_valid,
  output logic [DW-1:0]        up_data,
  output logic [CW-1:0]        up_ch,
  output logic                 up_sop,
  output logic                 up_eop,
  output logic                 busy
);

  localparam logic [LW-1:0] LAST   = LW'(BURST - 1);
  localparam logic [LW-1:0] THRESH = LW'(BURST);
  localparam logic [1:0]    DLAST  = 2'(DRAIN_CYC - 1);

  logic [CH_NUM-1:0][LW-1:0] lvl;
  logic [CH_NUM-1:0][DW-1:0] q_arr;
  logic [CH_NUM-1:0]         elig;
  logic [CW-1:0]             pick_gnt;
  logic                      pick_vld;

  state_t        state;
  logic [CW-1:0] gnt;
  logic [CW-1:0] rr_ptr;
  logic [LW-1:0] cnt;
  logic [1:0]    dcnt;

  assign lvl   = ch_level;
  assign q_arr = ch_q;

  // A channel qualifies once at least a full burst is buffered
  always_comb begin
    elig = '0;
    for (int k = 0; k < CH_NUM; k++) elig[k] = (lvl[k] >= THRESH);
  end

  rr_arbiter #(.N(CH_NUM), .IW(CW)) u_rr (
    .eligible (elig),
    .ptr      (rr_ptr),
    .gnt      (pick_gnt),
    .valid    (pick_vld)
  );

  // Grant / read / drain sequencer; ready is only looked at when idle
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      dcnt     <= '0;
      ch_rdreq <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld && up_ready) begin
            gnt      <= pick_gnt;
            cnt      <= '0;
            ch_rdreq <= CH_NUM'(1) << pick_gnt;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            ch_rdreq <= '0;
            dcnt     <= '0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) begin
            rr_ptr <= (gnt == CW'(CH_NUM - 1)) ? '0 : gnt + 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          ch_rdreq <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Each read cycle yields one output word on the following cycle
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid <= 1'b0;
      up_data  <= '0;
      up_ch    <= '0;
      up_sop   <= 1'b0;
      up_eop   <= 1'b0;
    end else if (state == READ) begin
      up_valid <= 1'b1;
      up_data  <= q_arr[gnt];
      up_ch    <= gnt;
      up_sop   <= (cnt == '0);
      up_eop   <= (cnt == LAST);
    end else begin
      up_valid <= 1'b0;
      up_sop   <= 1'b0;
      up_eop   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poll_burst_arbiter.sv
// Directed bench for poll_burst_arbiter with a cycle-timing reference model.
module tb_poll_burst_arbiter;

  localparam int CH_NUM = 4;
  localparam int DW     = 64;
  localparam int LW     = 13;
  localparam int BURST  = 128;
  localparam int CW     = 2;

  logic                      rdclk = 1'b0;
  logic                      rst_n;
  logic [CH_NUM-1:0][LW-1:0] lvl;
  logic [CH_NUM-1:0][DW-1:0] q_arr;
  logic [CH_NUM-1:0]         ch_rdreq;
  logic                      up_ready;
  logic                      up_valid;
  logic [DW-1:0]             up_data;
  logic [CW-1:0]             up_ch;
  logic                      up_sop;
  logic                      up_eop;
  logic                      busy;

  logic [31:0] rd_cnt [CH_NUM];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  bit act;
  int t0, mg, mbase, next_dec, ptr;
  int mreads [CH_NUM];

  // observation statistics
  int          rq_count [CH_NUM];
  int          sop_cyc [$];
  int          sop_ch [$];
  logic [63:0] sop_dat [$];
  int          eop_cyc;
  logic [63:0] eop_dat;
  int          vcount;
  int          first_rq;

  always #5 rdclk = ~rdclk;

  poll_burst_arbiter #(.CH_NUM(CH_NUM), .DW(DW), .LW(LW), .BURST(BURST)) dut (
    .rdclk    (rdclk),
    .rst_n    (rst_n),
    .ch_level (lvl),
    .ch_q     (q_arr),
    .ch_rdreq (ch_rdreq),
    .up_ready (up_ready),
    .up_valid (up_valid),
    .up_data  (up_data),
    .up_ch    (up_ch),
    .up_sop   (up_sop),
    .up_eop   (up_eop),
    .busy     (busy)
  );

  // FIFO stand-in: word = {channel, number of reads already taken}
  always_comb
    for (int k = 0; k < CH_NUM; k++) q_arr[k] = {32'(k), rd_cnt[k]};

  always @(posedge rdclk)
    for (int k = 0; k < CH_NUM; k++)
      if (!rst_n) rd_cnt[k] <= '0;
      else if (ch_rdreq[k]) rd_cnt[k] <= rd_cnt[k] + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < CH_NUM; k++) rq_count[k] = 0;
    sop_cyc.delete(); sop_ch.delete(); sop_dat.delete();
    eop_cyc = -1; eop_dat = '0; vcount = 0; first_rq = -1;
  endtask

  // Compare against the burst timeline, then decide the next grant, then log
  task automatic step();
    logic [CH_NUM-1:0] e_rq;
    bit e_v, e_b;
    int k;
    if (!rst_n) begin
      chk("rst_rdreq", 64'(ch_rdreq), 0);
      chk("rst_valid", 64'(up_valid), 0);
      chk("rst_data",  up_data, 0);
      chk("rst_ch",    64'(up_ch), 0);
      chk("rst_sop",   64'(up_sop), 0);
      chk("rst_eop",   64'(up_eop), 0);
      chk("rst_busy",  64'(busy), 0);
      act = 0; ptr = 0; next_dec = 0;
      for (int i = 0; i < CH_NUM; i++) mreads[i] = 0;
      return;
    end
    if (act && cyc > t0 + BURST + 2) act = 0;
    e_rq = (act && cyc >= t0 + 1 && cyc <= t0 + BURST) ? CH_NUM'(1) << mg : '0;
    e_v  = act && cyc >= t0 + 2 && cyc <= t0 + BURST + 1;
    e_b  = act && cyc >= t0 + 1 && cyc <= t0 + BURST + 2;
    chk("rdreq", 64'(ch_rdreq), 64'(e_rq));
    chk("valid", 64'(up_valid), 64'(e_v));
    chk("busy",  64'(busy), 64'(e_b));
    chk("sop",   64'(up_sop), 64'(e_v && cyc == t0 + 2));
    chk("eop",   64'(up_eop), 64'(e_v && cyc == t0 + BURST + 1));
    if (e_v) begin
      chk("data", up_data, {32'(mg), 32'(mbase + cyc - t0 - 2)});
      chk("up_ch", 64'(up_ch), 64'(mg));
    end
    if (!act && cyc >= next_dec && up_ready) begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        k = (ptr + i) % CH_NUM;
        if (int'(lvl[k]) >= BURST) mg = k;
      end
      for (int i = 0; i < CH_NUM; i++)
        if (!act && int'(lvl[(ptr + i) % CH_NUM]) >= BURST) begin
          act = 1; t0 = cyc; mg = (ptr + i) % CH_NUM;
        end
      if (act) begin
        mbase = mreads[mg]; mreads[mg] += BURST;
        ptr = (mg + 1) % CH_NUM; next_dec = cyc + BURST + 3;
      end
    end
    for (int i = 0; i < CH_NUM; i++) rq_count[i] += int'(ch_rdreq[i]);
    if (|ch_rdreq && first_rq < 0) first_rq = cyc;
    if (up_valid) vcount++;
    if (up_sop) begin sop_cyc.push_back(cyc); sop_ch.push_back(int'(up_ch)); sop_dat.push_back(up_data); end
    if (up_eop) begin eop_cyc = cyc; eop_dat = up_data; end
  endtask

  task automatic tick();
    @(negedge rdclk); step();
    @(posedge rdclk); cyc++; #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_sop(input int n, input int budget);
    int i = 0;
    while (sop_cyc.size() < n && i < budget) begin tick(); i++; end
    chk("sop_timeout", 64'(sop_cyc.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin tick(); i++; end
    chk("idle_timeout", 64'(busy), 0);
  endtask

  function automatic int rq_total();
    int s = 0;
    for (int k = 0; k < CH_NUM; k++) s += rq_count[k];
    return s;
  endfunction

  initial begin
    int rc, gc;
    rst_n = 1'b0; up_ready = 1'b0; lvl = '0;
    clear_stats();

    // reset with random inputs
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < CH_NUM; k++) lvl[k] = LW'($urandom_range(0, 400));
      up_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_busy_lit", 64'(busy), 0);
    chk("rst_rdreq_lit", 64'(ch_rdreq), 0);

    // release with nothing buffered
    lvl = '0; up_ready = 1'b1; rst_n = 1'b1;
    ticks(1000);
    chk("idle_no_reads", 64'(rq_total()), 0);

    // one below threshold never grants
    lvl[2] = 127;
    ticks(200);
    chk("lvl127_no_reads", 64'(rq_total()), 0);

    // exactly at threshold
    lvl[2] = 128; gc = cyc;
    wait_sop(1, 10);
    lvl[2] = 0;
    wait_idle(200);
    chk("single_sop_lat", 64'(sop_cyc[0] - gc), 2);
    chk("single_ch", 64'(sop_ch[0]), 2);
    chk("single_first", sop_dat[0], {32'd2, 32'd0});
    chk("single_last", eop_dat, {32'd2, 32'd127});
    chk("single_reads", 64'(rq_count[2]), 128);
    chk("single_words", 64'(vcount), 128);
    chk("single_eop_pos", 64'(eop_cyc - sop_cyc[0]), 127);

    // well above threshold still takes one burst only
    clear_stats();
    lvl[2] = 300;
    wait_sop(1, 10);
    lvl[2] = 0;
    wait_idle(200);
    chk("lvl300_reads", 64'(rq_count[2]), 128);
    chk("lvl300_first", sop_dat[0], {32'd2, 32'd128});

    // round robin from a fresh pointer
    rst_n = 1'b0; ticks(2); rst_n = 1'b1;
    clear_stats();
    lvl[0] = 200; lvl[1] = 200; lvl[3] = 200;
    wait_sop(4, 700);
    lvl = '0;
    wait_idle(200);
    chk("rr_g0", 64'(sop_ch[0]), 0);
    chk("rr_g1", 64'(sop_ch[1]), 1);
    chk("rr_g2", 64'(sop_ch[2]), 3);
    chk("rr_g3", 64'(sop_ch[3]), 0);
    for (int i = 1; i < 4; i++) chk("rr_period", 64'(sop_cyc[i] - sop_cyc[i-1]), BURST + 3);
    chk("rr_skip2", 64'(rq_count[2]), 0);

    // backpressure holds off the grant
    clear_stats();
    up_ready = 1'b0; lvl[1] = 200;
    ticks(50);
    chk("bp_no_reads", 64'(rq_total()), 0);
    up_ready = 1'b1; rc = cyc;
    wait_sop(1, 10);
    chk("bp_grant_lat", 64'(first_rq - rc), 1);
    up_ready = 1'b0; lvl[0] = 200;
    wait_idle(200);
    chk("np_ch1_reads", 64'(rq_count[1]), 128);
    chk("np_ch0_reads", 64'(rq_count[0]), 0);
    chk("np_eop_ch", 64'(sop_ch[0]), 1);
    lvl = '0;
    ticks(20);

    // reset in the middle of a burst
    clear_stats();
    up_ready = 1'b1; lvl[1] = 200; lvl[3] = 200;
    gc = 0;
    while (vcount < 41 && gc < 100) begin tick(); gc++; end
    chk("mid_timeout", 64'(vcount >= 41), 1);
    chk("mid_ch", 64'(sop_ch[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_clr_rdreq", 64'(ch_rdreq), 0);
    chk("mid_clr_valid", 64'(up_valid), 0);
    chk("mid_clr_data", up_data, 0);
    chk("mid_clr_busy", 64'(busy), 0);
    ticks(3);
    clear_stats();
    rst_n = 1'b1;
    wait_sop(1, 10);
    chk("post_rst_ch", 64'(sop_ch[0]), 1);
    lvl = '0;
    wait_idle(200);
    ticks(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
